// File: rtl/div_pkg.sv
// Shared encodings and constants for the RV32M divide/remainder unit.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t START = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t RESP  = 2'd3;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_divider.sv
// Unsigned iterative divider core: two setup cycles, then one restoring step per
// quotient bit; rdy_o pulses for one cycle with the results.
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        vld_i,
    input  logic [31:0] div1_i,
    input  logic [31:0] div2_i,
    output logic        rdy_o,
    output logic [31:0] res_q_o,
    output logic [31:0] res_r_o
);

    localparam logic [2:0] C_IDLE  = 3'd0;
    localparam logic [2:0] C_NORM  = 3'd1;
    localparam logic [2:0] C_ALIGN = 3'd2;
    localparam logic [2:0] C_BUSY  = 3'd3;
    localparam logic [2:0] C_DONE  = 3'd4;

    logic [2:0]  st_q, st_d;
    logic [4:0]  shift_q, shift_d, cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
    logic [4:0]  msb1, msb2;

    // Result is undefined for a zero input; callers must not divide zero.
    function automatic logic [4:0] msb_pos(input logic [31:0] v);
        logic [4:0] p;
        p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) p = 5'(i);
        end
        return p;
    endfunction

    assign msb1 = msb_pos(div1_i);
    assign msb2 = msb_pos(div2_i);

    always_comb begin
        st_d    = st_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        case (st_q)
            C_IDLE, C_DONE: begin
                if (vld_i) st_d = C_NORM;
                else       st_d = C_IDLE;
            end
            C_NORM: begin
                shift_d = (msb1 >= msb2) ? (msb1 - msb2) : 5'd0;
                st_d    = C_ALIGN;
            end
            C_ALIGN: begin
                dsr_d = div2_i << shift_q;
                rem_d = div1_i;
                quo_d = '0;
                cnt_d = shift_q;
                st_d  = C_BUSY;
            end
            C_BUSY: begin
                if (rem_q >= dsr_q) begin
                    rem_d = rem_q - dsr_q;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    quo_d = {quo_q[30:0], 1'b0};
                end
                dsr_d = dsr_q >> 1;
                if (cnt_q == 5'd0) st_d = C_DONE;
                else               cnt_d = cnt_q - 5'd1;
            end
            default: st_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= C_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
        end else begin
            st_q    <= st_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
        end
    end

    assign rdy_o   = (st_q == C_DONE);
    assign res_q_o = quo_q;
    assign res_r_o = rem_q;

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU execution unit wrapping the iterative divider core.
// Optional result reuse of the last core-computed operation: DIV_UNIT_REUSE_EN.
module div_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic [1:0]       req_op_i,
    input  logic [XLEN-1:0]  req_rs1_i,
    input  logic [XLEN-1:0]  req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_vld_o,
    input  logic             rsp_rdy_i,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);
    import div_pkg::*;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             negq_q, negq_d, negr_q, negr_d;
    logic [XLEN-1:0]  mag1_q, mag1_d, mag2_q, mag2_d, data_q, data_d;

    logic             core_vld, core_rdy;
    logic [XLEN-1:0]  core_q, core_r;

    logic             is_signed, s1, s2, div0, ovf, zero_dvd, special, core_done;
    logic [XLEN-1:0]  spec_quot, spec_rem, fin_quot, fin_rem;
    logic             reuse_hit;
    logic [XLEN-1:0]  reuse_quot, reuse_rem;

    assign is_signed = ~req_op_i[0];
    assign s1        = is_signed & req_rs1_i[XLEN-1];
    assign s2        = is_signed & req_rs2_i[XLEN-1];
    assign div0      = (req_rs2_i == '0);
    assign ovf       = is_signed && (req_rs1_i == INT_MIN) && (req_rs2_i == NEG_ONE);
    assign zero_dvd  = (req_rs1_i == '0);
    assign special   = div0 | ovf | zero_dvd;

    always_comb begin
        spec_quot = '0;
        spec_rem  = '0;
        if (div0) begin
            spec_quot = DIV0_QUOT;
            spec_rem  = req_rs1_i;
        end else if (ovf) begin
            spec_quot = INT_MIN;
        end
    end

    assign fin_quot  = neg_if(negq_q, core_q);
    assign fin_rem   = neg_if(negr_q, core_r);
    assign core_done = (state_q == WAIT) && core_rdy;

`ifdef DIV_UNIT_REUSE_EN
    logic            reuse_vld_q, reuse_sgn_q;
    logic [XLEN-1:0] reuse_rs1_q, reuse_rs2_q, reuse_quot_q, reuse_rem_q;

    assign reuse_hit  = reuse_vld_q && (reuse_sgn_q == is_signed) &&
                        (reuse_rs1_q == req_rs1_i) && (reuse_rs2_q == req_rs2_i);
    assign reuse_quot = reuse_quot_q;
    assign reuse_rem  = reuse_rem_q;

    // Key is latched when a core operation starts; results and valid land on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            reuse_vld_q  <= 1'b0;
            reuse_sgn_q  <= 1'b0;
            reuse_rs1_q  <= '0;
            reuse_rs2_q  <= '0;
            reuse_quot_q <= '0;
            reuse_rem_q  <= '0;
        end else if (state_q == IDLE && req_vld_i && !special && !reuse_hit) begin
            reuse_vld_q <= 1'b0;
            reuse_sgn_q <= is_signed;
            reuse_rs1_q <= req_rs1_i;
            reuse_rs2_q <= req_rs2_i;
        end else if (core_done) begin
            reuse_vld_q  <= 1'b1;
            reuse_quot_q <= fin_quot;
            reuse_rem_q  <= fin_rem;
        end
    end
`else
    assign reuse_hit  = 1'b0;
    assign reuse_quot = '0;
    assign reuse_rem  = '0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        mag1_d  = mag1_q;
        mag2_d  = mag2_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_vld_i) begin
                    op_d   = req_op_i;
                    tag_d  = req_tag_i;
                    negq_d = s1 ^ s2;
                    negr_d = s1;
                    mag1_d = s1 ? (~req_rs1_i + 1'b1) : req_rs1_i;
                    mag2_d = s2 ? (~req_rs2_i + 1'b1) : req_rs2_i;
                    if (special) begin
                        data_d  = req_op_i[1] ? spec_rem : spec_quot;
                        state_d = RESP;
                    end else if (reuse_hit) begin
                        data_d  = req_op_i[1] ? reuse_rem : reuse_quot;
                        state_d = RESP;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (core_rdy) begin
                    data_d  = op_q[1] ? fin_rem : fin_quot;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_rdy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            mag1_q  <= '0;
            mag2_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            mag1_q  <= mag1_d;
            mag2_q  <= mag2_d;
            data_q  <= data_d;
        end
    end

    // Core vld is only high in START, so it is never asserted alongside core rdy.
    assign core_vld = (state_q == START);

    divider u_divider (
        .clk     (clk),
        .rst     (rst),
        .vld_i   (core_vld),
        .div1_i  (mag1_q),
        .div2_i  (mag2_q),
        .rdy_o   (core_rdy),
        .res_q_o (core_q),
        .res_r_o (core_r)
    );

    assign req_rdy_o  = (state_q == IDLE);
    assign rsp_vld_o  = (state_q == RESP);
    assign rsp_data_o = data_q;
    assign rsp_tag_o  = tag_q;
    assign busy_o     = (state_q != IDLE);

endmodule
